// File: rtl/clk_cfg_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// clk_cfg_pkg: shared types and constants for clk_cfg_ctrl. Rev 1.0
// ------------------------------------------------------------------
package clk_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ       = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_LOCK_WAIT = 3'd3,
    ST_RESP      = 3'd4
  } state_t;

  localparam logic [1:0] DOM_SOC    = 2'd0;
  localparam logic [1:0] DOM_PER    = 2'd1;
  localparam logic [1:0] DOM_CLU    = 2'd2;
  localparam logic [1:0] DOM_STATUS = 2'd3;

  localparam int ST_LOCK_LSB    = 0;
  localparam int ST_ACKERR_LSB  = 8;
  localparam int ST_LOCKERR_LSB = 16;

  // The status code has no cfg port, so it maps to no request bit.
  function automatic logic [2:0] dom_onehot(input logic [1:0] dom);
    dom_onehot = (dom == DOM_STATUS) ? 3'b000 : (3'b001 << dom);
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_cfg_ctrl_if.sv
`default_nettype none
// ------------------------------------------------------------------
// clk_cfg_ctrl_if: host register-port bundle for clk_cfg_ctrl. Rev 1.0
// ------------------------------------------------------------------
interface clk_cfg_ctrl_if;
  logic        host_req_i;
  logic        host_gnt_o;
  logic [3:0]  host_addr_i;
  logic        host_we_i;
  logic [31:0] host_wdata_i;
  logic        host_rvalid_o;
  logic [31:0] host_rdata_o;
  logic        host_err_o;

  modport master (
    output host_req_i, host_addr_i, host_we_i, host_wdata_i,
    input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o
  );

  modport slave (
    input  host_req_i, host_addr_i, host_we_i, host_wdata_i,
    output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o
  );
endinterface
`default_nettype wire

// File: rtl/clk_cfg_timer.sv
`default_nettype none
// ------------------------------------------------------------------
// clk_cfg_timer: loadable saturating down-counter for timeouts. Rev 1.0
// ------------------------------------------------------------------
module clk_cfg_timer #(
  parameter int WIDTH = 5
) (
  input  logic             ref_clk_i,
  input  logic             rstn_glob_i,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge ref_clk_i or negedge rstn_glob_i) begin
    if (!rstn_glob_i) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule
`default_nettype wire

// File: rtl/clk_cfg_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// clk_cfg_ctrl: host-to-clk_gen cfg sequencer with timeouts. Rev 1.0
// ------------------------------------------------------------------
module clk_cfg_ctrl
  import clk_cfg_pkg::*;
#(
  parameter int ACK_TIMEOUT  = 16,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                ref_clk_i,
  input  logic                rstn_glob_i,
  clk_cfg_ctrl_if.slave       host,
  output logic [2:0]          cfg_req_o,
  input  logic [2:0]          cfg_ack_i,
  input  logic [2:0]          cfg_lock_i,
  output logic [1:0]          cfg_add_o,
  output logic [31:0]         cfg_data_o,
  output logic                cfg_wrn_o,
  input  logic [95:0]         cfg_r_data_i
);

  localparam int TMAX = (ACK_TIMEOUT > LOCK_TIMEOUT) ? ACK_TIMEOUT : LOCK_TIMEOUT;
  localparam int CW   = $clog2(TMAX + 1);
  localparam logic [CW-1:0] ACK_LOAD  = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] LOCK_LOAD = CW'(LOCK_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [3:0]  addr_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [2:0]  ack_err, lock_err;
  logic [1:0]  dom;
  logic [2:0]  dom_oh;
  logic        ack_hit, lock_hit;
  logic        ack_to, lock_to;
  logic        expired, load;
  logic [CW-1:0] load_val;
  logic [31:0] slice;
  logic [31:0] status_word;
  logic        status_wr;
  logic        grant;

  assign dom      = addr_q[3:2];
  assign dom_oh   = dom_onehot(dom);
  assign ack_hit  = |(cfg_ack_i & dom_oh);
  assign lock_hit = |(cfg_lock_i & dom_oh);
  assign grant    = (state == ST_IDLE) && host.host_req_i;

  // Ack timeout covers both a missing ack in REQ and a stuck ack in RELEASE.
  assign ack_to  = expired && (((state == ST_REQ) && !ack_hit) ||
                               ((state == ST_RELEASE) && ack_hit));
  assign lock_to = expired && (state == ST_LOCK_WAIT) && !lock_hit;

  // Every state change reloads the timer with the budget of the new state.
  assign load     = (state_nxt != state);
  assign load_val = (state_nxt == ST_LOCK_WAIT) ? LOCK_LOAD : ACK_LOAD;

  clk_cfg_timer #(.WIDTH(CW)) u_timer (
    .ref_clk_i   (ref_clk_i),
    .rstn_glob_i (rstn_glob_i),
    .load        (load),
    .load_val    (load_val),
    .expired     (expired)
  );

  always_ff @(posedge ref_clk_i or negedge rstn_glob_i) begin
    if (!rstn_glob_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (host.host_req_i) begin
          state_nxt = (host.host_addr_i[3:2] == DOM_STATUS) ? ST_RESP : ST_REQ;
        end
      end
      ST_REQ: begin
        if (ack_hit)      state_nxt = ST_RELEASE;
        else if (expired) state_nxt = ST_RESP;
      end
      ST_RELEASE: begin
        if (!ack_hit)     state_nxt = we_q ? ST_LOCK_WAIT : ST_RESP;
        else if (expired) state_nxt = ST_RESP;
      end
      ST_LOCK_WAIT: begin
        if (lock_hit || expired) state_nxt = ST_RESP;
      end
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    case (dom)
      DOM_SOC: slice = cfg_r_data_i[31:0];
      DOM_PER: slice = cfg_r_data_i[63:32];
      DOM_CLU: slice = cfg_r_data_i[95:64];
      default: slice = '0;
    endcase
  end

  always_ff @(posedge ref_clk_i or negedge rstn_glob_i) begin
    if (!rstn_glob_i) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (grant) begin
      addr_q  <= host.host_addr_i;
      we_q    <= host.host_we_i;
      wdata_q <= host.host_wdata_i;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (ack_to || lock_to) begin
      rdata_q <= '0;
      err_q   <= 1'b1;
    end else if ((state == ST_REQ) && ack_hit) begin
      rdata_q <= slice;
    end
  end

  assign status_wr = (state == ST_RESP) && we_q && (dom == DOM_STATUS) && (addr_q[1:0] == 2'b00);

  // Set is ORed in after the clear so a simultaneous timeout always sticks.
  always_ff @(posedge ref_clk_i or negedge rstn_glob_i) begin
    if (!rstn_glob_i) begin
      ack_err  <= '0;
      lock_err <= '0;
    end else begin
      ack_err  <= (ack_err  & ~(status_wr ? wdata_q[ST_ACKERR_LSB +: 3]  : 3'b000)) |
                  (ack_to  ? dom_oh : 3'b000);
      lock_err <= (lock_err & ~(status_wr ? wdata_q[ST_LOCKERR_LSB +: 3] : 3'b000)) |
                  (lock_to ? dom_oh : 3'b000);
    end
  end

  always_comb begin
    status_word = '0;
    status_word[ST_LOCK_LSB    +: 3] = cfg_lock_i;
    status_word[ST_ACKERR_LSB  +: 3] = ack_err;
    status_word[ST_LOCKERR_LSB +: 3] = lock_err;
  end

  always_comb begin
    cfg_req_o          = (state == ST_REQ) ? dom_oh : 3'b000;
    host.host_gnt_o    = grant && rstn_glob_i;
    host.host_rvalid_o = (state == ST_RESP);
    host.host_err_o    = (state == ST_RESP) && err_q;
    host.host_rdata_o  = '0;
    if ((state == ST_RESP) && !we_q) begin
      if (dom != DOM_STATUS)        host.host_rdata_o = rdata_q;
      else if (addr_q[1:0] == 2'b00) host.host_rdata_o = status_word;
    end
  end

  assign cfg_add_o  = addr_q[1:0];
  assign cfg_data_o = wdata_q;
  assign cfg_wrn_o  = we_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_cfg_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_clk_cfg_ctrl: directed self-checking bench for clk_cfg_ctrl. Rev 1.0
// ------------------------------------------------------------------
module tb_clk_cfg_ctrl;

  logic        ref_clk_i;
  logic        rstn_glob_i;
  logic [2:0]  cfg_req;
  logic [2:0]  cfg_ack;
  logic [2:0]  cfg_lock;
  logic [1:0]  cfg_add;
  logic [31:0] cfg_data;
  logic        cfg_wrn;
  logic [95:0] cfg_r_data;
  logic [2:0]  ack_mask;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int outstanding = 0;
  int busy_gnt    = 0;

  clk_cfg_ctrl_if h();

  clk_cfg_ctrl #(.ACK_TIMEOUT(16), .LOCK_TIMEOUT(64)) dut (
    .ref_clk_i    (ref_clk_i),
    .rstn_glob_i  (rstn_glob_i),
    .host         (h),
    .cfg_req_o    (cfg_req),
    .cfg_ack_i    (cfg_ack),
    .cfg_lock_i   (cfg_lock),
    .cfg_add_o    (cfg_add),
    .cfg_data_o   (cfg_data),
    .cfg_wrn_o    (cfg_wrn),
    .cfg_r_data_i (cfg_r_data)
  );

  // clk_gen stand-in: ack follows req combinationally unless masked off.
  assign cfg_ack = cfg_req & ack_mask;

  initial ref_clk_i = 1'b0;
  always #5 ref_clk_i = ~ref_clk_i;

  always @(posedge ref_clk_i) cyc <= cyc + 1;

  always begin
    @(negedge ref_clk_i);
    #2;
    if (!rstn_glob_i) begin
      outstanding <= 0;
    end else begin
      if (h.host_gnt_o && outstanding != 0) busy_gnt <= busy_gnt + 1;
      outstanding <= outstanding + int'(h.host_gnt_o) - int'(h.host_rvalid_o);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One host access; returns data, err, gnt-to-rvalid latency, cycles with
  // any cfg_req high, OR of cfg_req seen, and cfg bus stability.
  task automatic do_access(input logic [3:0] a, input logic w, input logic [31:0] d,
                           output logic [31:0] rd, output logic er, output int lat,
                           output int req_hi, output logic [2:0] req_seen,
                           output logic stable);
    int  t0;
    bit  got;
    rd = '0; er = 1'b0; lat = -1; req_hi = 0; req_seen = '0; stable = 1'b1; t0 = 0;
    @(negedge ref_clk_i);
    h.host_req_i = 1'b1; h.host_addr_i = a; h.host_we_i = w; h.host_wdata_i = d;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      #1;
      if (h.host_gnt_o) begin got = 1; t0 = cyc; end
      else @(negedge ref_clk_i);
    end
    if (!got) begin
      h.host_req_i = 1'b0;
      check_val("gnt_timeout", 32'd0, 32'd1);
      return;
    end
    @(negedge ref_clk_i);
    h.host_req_i = 1'b0;
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      #1;
      req_seen = req_seen | cfg_req;
      if (cfg_req != 3'b000) req_hi++;
      if (cfg_data !== d || cfg_add !== a[1:0] || cfg_wrn !== w) stable = 1'b0;
      if (h.host_rvalid_o) begin
        got = 1; lat = cyc - t0; rd = h.host_rdata_o; er = h.host_err_o;
      end else begin
        @(negedge ref_clk_i);
      end
    end
    if (!got) check_val("rvalid_timeout", 32'd0, 32'd1);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, req_hi, lock_rise;
  logic [2:0]  seen;
  logic        stable;
  logic        rv_during_rst;
  logic [31:0] rd6 [3];
  int          gcy [3];
  int          rcy [3];
  logic [3:0]  va  [3];
  int          gi, nrv;
  bit          gflag;

  initial begin
    rstn_glob_i = 1'b0;
    h.host_req_i = 1'b0; h.host_addr_i = '0; h.host_we_i = 1'b0; h.host_wdata_i = '0;
    ack_mask   = 3'b111;
    cfg_lock   = 3'b011;
    cfg_r_data = {32'hCAFE0003, 32'h00020002, 32'h11110000};

    #12;
    check_val("rst_cfg_req",  {29'd0, cfg_req}, 32'd0);
    check_val("rst_rvalid",   {31'd0, h.host_rvalid_o}, 32'd0);
    check_val("rst_gnt",      {31'd0, h.host_gnt_o}, 32'd0);
    check_val("rst_cfg_data", cfg_data, 32'd0);
    check_val("rst_misc",     {26'd0, h.host_err_o, cfg_wrn, cfg_add, 2'b00}, 32'd0);
    @(negedge ref_clk_i);
    rstn_glob_i = 1'b1;

    // Read per register 01 with combinational ack.
    do_access(4'b0101, 1'b0, 32'h0, rd, er, lat, req_hi, seen, stable);
    check_val("rd_per_lat",  lat, 32'd3);
    check_val("rd_per_data", rd, 32'h00020002);
    check_val("rd_per_err",  {31'd0, er}, 32'd0);
    check_val("rd_per_req",  {29'd0, seen}, 32'b010);

    do_access(4'b1100, 1'b0, 32'h0, rd, er, lat, req_hi, seen, stable);
    check_val("st_rd_lat",  lat, 32'd1);
    check_val("st_rd_data", rd, 32'h00000003);
    do_access(4'b1101, 1'b0, 32'h0, rd, er, lat, req_hi, seen, stable);
    check_val("st_reg1",    rd, 32'h0);

    // Write soc with lock already high.
    do_access(4'b0001, 1'b1, 32'h000000A5, rd, er, lat, req_hi, seen, stable);
    check_val("wr_soc_lat", lat, 32'd4);
    check_val("wr_soc_err", {31'd0, er}, 32'd0);

    // Write cluster, lock low then rising 21 cycles after the grant cycle.
    cfg_lock[2] = 1'b0;
    lock_rise = 0;
    fork
      do_access(4'b1000, 1'b1, 32'h12345678, rd, er, lat, req_hi, seen, stable);
      begin
        repeat (22) @(negedge ref_clk_i);
        cfg_lock[2] = 1'b1;
        lock_rise = cyc;
      end
    join
    check_val("wr_clu_lat",    lat, 32'd22);
    check_val("wr_clu_err",    {31'd0, er}, 32'd0);
    check_val("wr_clu_stable", {31'd0, stable}, 32'd1);

    // Soc ack never arrives.
    ack_mask = 3'b110;
    do_access(4'b0010, 1'b0, 32'h0, rd, er, lat, req_hi, seen, stable);
    ack_mask = 3'b111;
    check_val("ackto_req_hi", req_hi, 32'd16);
    check_val("ackto_lat",    lat, 32'd17);
    check_val("ackto_err",    {31'd0, er}, 32'd1);
    check_val("ackto_rdata",  rd, 32'h0);
    do_access(4'b1100, 1'b0, 32'h0, rd, er, lat, req_hi, seen, stable);
    check_val("ackto_status", rd, 32'h00000107);
    do_access(4'b1100, 1'b1, 32'h00000100, rd, er, lat, req_hi, seen, stable);
    do_access(4'b1100, 1'b0, 32'h0, rd, er, lat, req_hi, seen, stable);
    check_val("ackerr_w1c",   rd, 32'h00000007);

    // Per write with lock stuck low.
    cfg_lock[1] = 1'b0;
    do_access(4'b0100, 1'b1, 32'hDEAD0001, rd, er, lat, req_hi, seen, stable);
    check_val("lockto_lat", lat, 32'd67);
    check_val("lockto_err", {31'd0, er}, 32'd1);
    do_access(4'b1100, 1'b0, 32'h0, rd, er, lat, req_hi, seen, stable);
    check_val("lockto_status", rd, 32'h00020005);
    cfg_lock[1] = 1'b1;
    do_access(4'b1100, 1'b1, 32'h00020000, rd, er, lat, req_hi, seen, stable);
    do_access(4'b1100, 1'b0, 32'h0, rd, er, lat, req_hi, seen, stable);
    check_val("lockerr_w1c", rd, 32'h00000007);

    // Leave a soc ack timeout pending in the sticky bits, then reset mid-REQ.
    ack_mask = 3'b110;
    do_access(4'b0000, 1'b0, 32'h0, rd, er, lat, req_hi, seen, stable);
    @(negedge ref_clk_i);
    h.host_req_i = 1'b1; h.host_addr_i = 4'b0000; h.host_we_i = 1'b0; h.host_wdata_i = '0;
    #1;
    check_val("rst_gnt_seen", {31'd0, h.host_gnt_o}, 32'd1);
    @(negedge ref_clk_i);
    h.host_req_i = 1'b0;
    #1;
    check_val("rst_in_req", {29'd0, cfg_req}, 32'b001);
    #2;
    rstn_glob_i = 1'b0;
    #1;
    check_val("rst_async_req", {29'd0, cfg_req}, 32'd0);
    rv_during_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge ref_clk_i); #1;
      rv_during_rst = rv_during_rst | h.host_rvalid_o;
    end
    check_val("rst_no_rvalid", {31'd0, rv_during_rst}, 32'd0);
    @(negedge ref_clk_i);
    rstn_glob_i = 1'b1;
    ack_mask = 3'b111;
    do_access(4'b0101, 1'b0, 32'h0, rd, er, lat, req_hi, seen, stable);
    check_val("post_rst_lat",  lat, 32'd3);
    check_val("post_rst_data", rd, 32'h00020002);
    do_access(4'b1100, 1'b0, 32'h0, rd, er, lat, req_hi, seen, stable);
    check_val("post_rst_sticky", rd, 32'h00000007);

    // Three accesses with host_req_i held high throughout.
    va[0] = 4'b0101; va[1] = 4'b1100; va[2] = 4'b1011;
    gi = 0; nrv = 0;
    @(negedge ref_clk_i);
    h.host_req_i = 1'b1; h.host_addr_i = va[0]; h.host_we_i = 1'b0;
    for (int i = 0; i < 100 && nrv < 3; i++) begin
      #1;
      gflag = 0;
      if (h.host_gnt_o) begin
        if (gi < 3) gcy[gi] = cyc;
        gi++; gflag = 1;
      end
      if (h.host_rvalid_o) begin
        if (nrv < 3) begin rd6[nrv] = h.host_rdata_o; rcy[nrv] = cyc; end
        nrv++;
      end
      @(negedge ref_clk_i);
      if (gflag) begin
        if (gi < 3) h.host_addr_i = va[gi];
        else h.host_req_i = 1'b0;
      end
    end
    h.host_req_i = 1'b0;
    check_val("b2b_gnts",    gi, 32'd3);
    check_val("b2b_rvalids", nrv, 32'd3);
    if (nrv == 3 && gi == 3) begin
      check_val("b2b_rd0", rd6[0], 32'h00020002);
      check_val("b2b_rd1", rd6[1], 32'h00000007);
      check_val("b2b_rd2", rd6[2], 32'hCAFE0003);
      check_val("b2b_gap1", {31'd0, gcy[1] > rcy[0]}, 32'd1);
      check_val("b2b_gap2", {31'd0, gcy[2] > rcy[1]}, 32'd1);
    end
    repeat (2) @(negedge ref_clk_i);
    check_val("busy_gnt", busy_gnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
